// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with load-use stall FSM and flush
module id_ex_register #(
    parameter int DATA_W     = 16,
    parameter int LOAD_STALL = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [23:0]       code_instruction_in,
    input  logic [DATA_W-1:0] regA_in,
    input  logic [DATA_W-1:0] regB_in,
    input  logic [3:0]        regA_adress_in,
    input  logic [3:0]        regB_adress_in,
    input  logic [3:0]        regC_adress_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              write_inst_in,
    input  logic              mem_read_in,
    input  logic              flush_in,
    output logic [23:0]       code_instruction_out,
    output logic [DATA_W-1:0] regA_out,
    output logic [DATA_W-1:0] regB_out,
    output logic [3:0]        regA_adress_out,
    output logic [3:0]        regB_adress_out,
    output logic [3:0]        regC_adress_out,
    output logic [DATA_W-1:0] pc_out,
    output logic              write_inst_out,
    output logic              mem_read_out,
    output logic              stall_out,
    output logic [15:0]       bubble_count_out
);

    typedef enum logic {RUN, STALL} state_t;

    // Remaining STALL cycles after the first bubble, minus one
    localparam logic [1:0] CNT_INIT = 2'((LOAD_STALL > 1) ? (LOAD_STALL - 2) : 0);

    state_t     state, state_nx;
    logic [1:0] cnt, cnt_nx;
    logic       hazard;
    logic       stall;
    logic       take_in;
    logic       count_bubble;

    assign hazard = mem_read_out & write_inst_out &
                    ((regC_adress_out == regA_adress_in) | (regC_adress_out == regB_adress_in));

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        stall        = 1'b0;
        take_in      = 1'b0;
        count_bubble = 1'b0;
        case (state)
            RUN: begin
                if (flush_in) begin
                    cnt_nx = 2'd0;
                end else if (hazard) begin
                    stall        = 1'b1;
                    count_bubble = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_nx = STALL;
                        cnt_nx   = CNT_INIT;
                    end
                end else begin
                    take_in = 1'b1;
                end
            end
            STALL: begin
                if (flush_in) begin
                    state_nx = RUN;
                    cnt_nx   = 2'd0;
                end else begin
                    stall        = 1'b1;
                    count_bubble = 1'b1;
                    if (cnt == 2'd0) begin
                        state_nx = RUN;
                    end else begin
                        cnt_nx = cnt - 2'd1;
                    end
                end
            end
            default: begin
                state_nx = RUN;
                cnt_nx   = 2'd0;
            end
        endcase
    end

    // Reset must drop the stall request even though it is combinational
    assign stall_out = stall & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= RUN;
            cnt                  <= 2'd0;
            code_instruction_out <= '0;
            regA_out             <= '0;
            regB_out             <= '0;
            regA_adress_out      <= '0;
            regB_adress_out      <= '0;
            regC_adress_out      <= '0;
            pc_out               <= '0;
            write_inst_out       <= 1'b0;
            mem_read_out         <= 1'b0;
            bubble_count_out     <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (take_in) begin
                code_instruction_out <= code_instruction_in;
                regA_out             <= regA_in;
                regB_out             <= regB_in;
                regA_adress_out      <= regA_adress_in;
                regB_adress_out      <= regB_adress_in;
                regC_adress_out      <= regC_adress_in;
                pc_out               <= pc_in;
                write_inst_out       <= write_inst_in;
                mem_read_out         <= mem_read_in;
            end else begin
                code_instruction_out <= '0;
                regA_out             <= '0;
                regB_out             <= '0;
                regA_adress_out      <= '0;
                regB_adress_out      <= '0;
                regC_adress_out      <= '0;
                pc_out               <= '0;
                write_inst_out       <= 1'b0;
                mem_read_out         <= 1'b0;
            end
            if (count_bubble && (bubble_count_out != 16'hFFFF)) begin
                bubble_count_out <= bubble_count_out + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_register.sv
// tb/tb_id_ex_register.sv - checks id_ex_register with LOAD_STALL=1 and LOAD_STALL=3
module tb_id_ex_register;

    typedef struct packed {
        logic [23:0] code;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] pc;
        logic [3:0]  aad;
        logic [3:0]  bad;
        logic [3:0]  cad;
        logic        w;
        logic        mr;
    } ex_t;

    typedef struct {
        ex_t         in;
        logic        fl;
        logic        e_stall;
        logic [23:0] e_code;
        logic [3:0]  e_cad;
        logic        e_w;
        logic [15:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    ex_t  in_cur = '0;

    logic [23:0] code1, code3;
    logic [15:0] a1, a3, b1, b3, pc1, pc3, cnt1, cnt3;
    logic [3:0]  aad1, aad3, bad1, bad3, cad1, cad3;
    logic        w1, w3, mr1, mr3, st1, st3;

    int n_checks = 0;
    int n_fail = 0;

    ex_t m [2];
    int  left [2];
    int  mcnt [2];
    int  ls [2] = '{1, 3};

    always #5 clk = ~clk;

    id_ex_register #(.DATA_W(16), .LOAD_STALL(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .code_instruction_in(in_cur.code), .regA_in(in_cur.a), .regB_in(in_cur.b),
        .regA_adress_in(in_cur.aad), .regB_adress_in(in_cur.bad), .regC_adress_in(in_cur.cad),
        .pc_in(in_cur.pc), .write_inst_in(in_cur.w), .mem_read_in(in_cur.mr), .flush_in(flush),
        .code_instruction_out(code1), .regA_out(a1), .regB_out(b1),
        .regA_adress_out(aad1), .regB_adress_out(bad1), .regC_adress_out(cad1),
        .pc_out(pc1), .write_inst_out(w1), .mem_read_out(mr1),
        .stall_out(st1), .bubble_count_out(cnt1)
    );

    id_ex_register #(.DATA_W(16), .LOAD_STALL(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .code_instruction_in(in_cur.code), .regA_in(in_cur.a), .regB_in(in_cur.b),
        .regA_adress_in(in_cur.aad), .regB_adress_in(in_cur.bad), .regC_adress_in(in_cur.cad),
        .pc_in(in_cur.pc), .write_inst_in(in_cur.w), .mem_read_in(in_cur.mr), .flush_in(flush),
        .code_instruction_out(code3), .regA_out(a3), .regB_out(b3),
        .regA_adress_out(aad3), .regB_adress_out(bad3), .regC_adress_out(cad3),
        .pc_out(pc3), .write_inst_out(w3), .mem_read_out(mr3),
        .stall_out(st3), .bubble_count_out(cnt3)
    );

    wire ex_t ex1 = '{code1, a1, b1, pc1, aad1, bad1, cad1, w1, mr1};
    wire ex_t ex3 = '{code3, a3, b3, pc3, aad3, bad3, cad3, w3, mr3};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a load in EX costs LOAD_STALL bubbles; flush discards and cancels any pending stall
    function automatic logic m_stall(int i);
        if (flush) return 1'b0;
        if (left[i] > 0) return 1'b1;
        return m[i].mr && m[i].w && (m[i].cad == in_cur.aad || m[i].cad == in_cur.bad);
    endfunction

    task automatic m_update(input int i, input logic st);
        if (flush) begin
            m[i] = '0;
            left[i] = 0;
        end else if (st) begin
            left[i] = (left[i] > 0) ? left[i] - 1 : ls[i] - 1;
            m[i] = '0;
            if (mcnt[i] < 65535) mcnt[i]++;
        end else begin
            m[i] = in_cur;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m[i] = '0;
            left[i] = 0;
            mcnt[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        m_reset();
        chk("reset_ex1", ex1, '0);
        chk("reset_ex3", ex3, '0);
        chk("reset_stall", {st1, st3}, 2'b00);
        chk("reset_cnt", {cnt1, cnt3}, 32'd0);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [23:0] code, input logic [3:0] aad, input logic [3:0] bad,
                          input logic [3:0] cad, input logic w, input logic mr, input logic fl);
        in_cur = '{code, 16'h0, 16'h0, 16'h0, aad, bad, cad, w, mr};
        flush = fl;
        #1;
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{'{24'd620, 16'd9, 16'd12, 16'd4, 4'd1, 4'd2, 4'd5, 1'b1, 1'b0}, 1'b0, 1'b0, 24'd620, 4'd5, 1'b1, 16'd0};
        vecs[1] = '{'{24'h123, 16'd0, 16'd0, 16'd8, 4'd3, 4'd4, 4'd5, 1'b1, 1'b1}, 1'b0, 1'b0, 24'h123, 4'd5, 1'b1, 16'd0};
        vecs[2] = '{'{24'h777, 16'd1, 16'd2, 16'd12, 4'd5, 4'd0, 4'd6, 1'b1, 1'b0}, 1'b0, 1'b1, 24'h0, 4'd0, 1'b0, 16'd1};
        vecs[3] = '{'{24'h777, 16'd1, 16'd2, 16'd12, 4'd5, 4'd0, 4'd6, 1'b1, 1'b0}, 1'b0, 1'b0, 24'h777, 4'd6, 1'b1, 16'd1};
        vecs[4] = '{'{24'h55, 16'd0, 16'd0, 16'd16, 4'd1, 4'd2, 4'd7, 1'b1, 1'b1}, 1'b0, 1'b0, 24'h55, 4'd7, 1'b1, 16'd1};
        vecs[5] = '{'{24'h99, 16'd0, 16'd0, 16'd20, 4'd1, 4'd7, 4'd3, 1'b1, 1'b0}, 1'b1, 1'b0, 24'h0, 4'd0, 1'b0, 16'd1};
        vecs[6] = '{'{24'hAB, 16'd0, 16'd0, 16'd24, 4'd1, 4'd2, 4'd2, 1'b1, 1'b0}, 1'b0, 1'b0, 24'hAB, 4'd2, 1'b1, 16'd1};
        vecs[7] = '{'{24'h31, 16'd0, 16'd0, 16'd28, 4'd0, 4'd0, 4'd2, 1'b0, 1'b1}, 1'b0, 1'b0, 24'h31, 4'd2, 1'b0, 16'd1};
        vecs[8] = '{'{24'h42, 16'd0, 16'd0, 16'd32, 4'd2, 4'd2, 4'd9, 1'b1, 1'b0}, 1'b0, 1'b0, 24'h42, 4'd9, 1'b1, 16'd1};

        // Directed table on the LOAD_STALL=1 instance
        #2;
        do_reset();
        edge_settle();
        for (int i = 0; i < 9; i++) begin
            in_cur = vecs[i].in;
            flush = vecs[i].fl;
            #1;
            chk($sformatf("tbl%0d_stall", i), st1, vecs[i].e_stall);
            edge_settle();
            chk($sformatf("tbl%0d_code", i), code1, vecs[i].e_code);
            chk($sformatf("tbl%0d_cad", i), cad1, vecs[i].e_cad);
            chk($sformatf("tbl%0d_w", i), w1, vecs[i].e_w);
            chk($sformatf("tbl%0d_cnt", i), cnt1, vecs[i].e_cnt);
            if (i == 0) chk("tbl0_data", {a1, b1, pc1}, {16'd9, 16'd12, 16'd4});
        end

        // Three-cycle stall on regB hazard
        do_reset();
        set_in(24'h10, 4'd1, 4'd2, 4'd5, 1'b1, 1'b1, 1'b0);
        edge_settle();
        set_in(24'h20, 4'd0, 4'd5, 4'd8, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("ls3_stall%0d", k), st3, 1'b1);
            edge_settle();
            chk($sformatf("ls3_bubble%0d", k), {code3, w3, mr3}, 26'd0);
            chk($sformatf("ls3_cnt%0d", k), cnt3, k);
        end
        chk("ls3_run_stall", st3, 1'b0);
        edge_settle();
        chk("ls3_pass_code", {code3, cad3}, {24'h20, 4'd8});
        chk("ls3_pass_cnt", cnt3, 16'd3);

        // Flush on the second stall cycle
        do_reset();
        set_in(24'h10, 4'd1, 4'd2, 4'd5, 1'b1, 1'b1, 1'b0);
        edge_settle();
        set_in(24'h20, 4'd0, 4'd5, 4'd8, 1'b1, 1'b0, 1'b0);
        chk("fl_stall1", st3, 1'b1);
        edge_settle();
        flush = 1'b1;
        #1;
        chk("fl_stall2", st3, 1'b0);
        edge_settle();
        chk("fl_bubble", {code3, w3}, 25'd0);
        chk("fl_cnt", cnt3, 16'd1);
        flush = 1'b0;
        #1;
        chk("fl_run_stall", st3, 1'b0);
        edge_settle();
        chk("fl_run_code", code3, 24'h20);

        // Reset asserted mid-STALL, then a clean instruction after release
        do_reset();
        set_in(24'h10, 4'd1, 4'd2, 4'd5, 1'b1, 1'b1, 1'b0);
        edge_settle();
        set_in(24'h20, 4'd5, 4'd0, 4'd8, 1'b1, 1'b0, 1'b0);
        edge_settle();
        chk("rs_in_stall", st3, 1'b1);
        do_reset();
        set_in(24'd470, 4'd1, 4'd2, 4'd13, 1'b1, 1'b0, 1'b0);
        chk("rs_after_stall", st3, 1'b0);
        edge_settle();
        chk("rs_after_code", {code3, cad3, w3}, {24'd470, 4'd13, 1'b1});
        chk("rs_after_cnt", cnt3, 16'd0);

        // Randomized traffic against the reference model on both instances
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic s1, s3;
            if ($urandom_range(99) == 0) do_reset();
            in_cur = '{24'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                       4'($urandom_range(3)), 4'($urandom_range(3)), 4'($urandom_range(3)),
                       1'($urandom), 1'($urandom)};
            flush = ($urandom_range(7) == 0);
            #1;
            s1 = m_stall(0);
            s3 = m_stall(1);
            chk("rnd_stall1", st1, s1);
            chk("rnd_stall3", st3, s3);
            @(posedge clk);
            m_update(0, s1);
            m_update(1, s3);
            #1;
            chk("rnd_ex1", ex1, m[0]);
            chk("rnd_ex3", ex3, m[1]);
            chk("rnd_cnt", {cnt1, cnt3}, {16'(mcnt[0]), 16'(mcnt[1])});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 Parameter DATA_W, default 16, width of register-bank operands and PC.
REQ-002 Parameter LOAD_STALL, default 1, bubble cycles per load-use hazard; legal range 1..3.
REQ-003 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset; asynchronous, active-low.
REQ-005 code_instruction_in  in  24  decoded instruction word from ID.
REQ-006 regA_in, regB_in  in  DATA_W each  register-bank read operands.
REQ-007 regA_adress_in, regB_adress_in  in  4 each  source register addresses of ID instruction.
REQ-008 regC_adress_in  in  4  destination register address.
REQ-009 pc_in  in  DATA_W  PC of ID instruction.
REQ-010 write_inst_in  in  1  ID instruction writes regC.
REQ-011 mem_read_in  in  1  ID instruction is a load.
REQ-012 flush_in  in  1  branch taken; discard ID instruction.
REQ-013 code_instruction_out, regA_out, regB_out, regA_adress_out, regB_adress_out, regC_adress_out, pc_out, write_inst_out, mem_read_out  out  same widths  registered EX-stage copies feeding the hazard controller and EX/WB register.
REQ-014 stall_out  out  1  hold PC and IF/ID this cycle.
REQ-015 bubble_count_out  out  16  saturating count of stall bubbles inserted.

Function
REQ-016 Hazard = mem_read_out & write_inst_out & (regC_adress_out == regA_adress_in | regC_adress_out == regB_adress_in); combinational from current EX copy and ID inputs.
REQ-017 FSM states RUN and STALL; counter cnt, 2 bits.
REQ-018 RUN, flush_in=1: load bubble; stay RUN; cnt=0; stall_out=0.
REQ-019 RUN, flush_in=0, hazard=1: stall_out=1; load bubble; LOAD_STALL=1 -> stay RUN; LOAD_STALL>1 -> go STALL, cnt=LOAD_STALL-2.
REQ-020 RUN, flush_in=0, hazard=0: stall_out=0; load all *_in into *_out.
REQ-021 STALL, flush_in=0: stall_out=1; load bubble; cnt=0 -> RUN, else cnt decrements.
REQ-022 STALL, flush_in=1: stall_out=0; load bubble; go RUN; cnt=0 (flush overrides stall).
REQ-023 Bubble = code_instruction_out=0, write_inst_out=0, mem_read_out=0, all address, data and pc outputs=0.
REQ-024 Latency: one clock from *_in to *_out when not stalled or flushed.
REQ-025 bubble_count_out increments by 1 per stall bubble (REQ-019, REQ-021 cases), not per flush bubble; saturates at 16'hFFFF.
REQ-026 A bubble in EX never raises hazard, so one load yields exactly LOAD_STALL bubbles.
REQ-027 stall_out is combinational; no other output depends combinationally on inputs.

Reset
REQ-028 reset_n=0 at any time, including mid-STALL: state=RUN, cnt=0, all registered outputs=0, bubble_count_out=0, immediately without clock.
REQ-029 reset_n=0 forces stall_out=0; first rising edge after release behaves as REQ-020 (or REQ-018 if flush_in=1).

Verification
REQ-030 No hazard: code=620, regA_in=9, regB_in=12, regC=5, write=1, pc=4 -> next edge outputs equal inputs, stall_out=0 throughout.
REQ-031 Load-use, LOAD_STALL=1: EX holds load regC_adress_out=5, ID regA_adress_in=5 -> stall_out=1 that cycle, next edge bubble (code_out=0, write_out=0), bubble_count_out=1; following cycle stall_out=0 and ID instruction passes.
REQ-032 LOAD_STALL=3, same hazard on regB_adress_in=5 -> stall_out=1 for 3 consecutive cycles, 3 bubbles, bubble_count_out=3, then RUN.
REQ-033 Flush during STALL (LOAD_STALL=3, flush_in=1 on second stall cycle) -> stall_out=0 that cycle, bubble loaded, state RUN, bubble_count_out=1.
REQ-034 Hazard and flush_in=1 same cycle -> stall_out=0, bubble loaded, bubble_count_out unchanged.
REQ-035 reset_n pulled low mid-STALL -> all outputs 0 asynchronously; after release with code=470, regC=13, write=1 -> next edge code_instruction_out=470, regC_adress_out=13.
